cordic_ip_prescale: RTL and testbench

CORDIC_IP_PRESCALE -- requirements
Module: cordic_ip_prescale

---
 rtl/cordic_pkg.sv | 18 +
 rtl/cordic_rsb_count.sv | 29 ++
 rtl/cordic_ip_prescale.sv | 97 +++++++++
 tb/tb_cordic_ip_prescale.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared default widths and width helpers for the CORDIC prescaler
package cordic_pkg;

   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_CORDIC_WIDTH = 22;
   localparam int DEF_MAX_SHIFT    = 8;

   // Fractional guard bits appended below the input word.
   function automatic int guard_bits(input int data_width, input int cordic_width);
      return cordic_width - data_width;
   endfunction

   // Width able to hold 0..max_shift, never narrower than one bit.
   function automatic int shift_width(input int max_shift);
      return (max_shift < 1) ? 1 : $clog2(max_shift + 1);
   endfunction

endpackage

// File: rtl/cordic_rsb_count.sv
// rtl/cordic_rsb_count.sv - combinational redundant-sign-bit counter
module cordic_rsb_count
   import cordic_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH
)
(
   input  logic [WIDTH-1:0]         din,
   output logic [$clog2(WIDTH)-1:0] rsb
);

   localparam int RW = $clog2(WIDTH);

   logic run;

   // Count bits below the MSB that match it, stopping at the first differing bit.
   always_comb begin
      rsb = '0;
      run = 1'b1;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (run && (din[i] == din[WIDTH-1])) begin
            rsb = rsb + RW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cordic_ip_prescale.sv
// rtl/cordic_ip_prescale.sv - two-stage CORDIC input prescaler; normalisation built with CORDIC_IP_PRESCALE_NORM_EN
module cordic_ip_prescale
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int CORDIC_WIDTH = DEF_CORDIC_WIDTH,
   parameter int MAX_SHIFT    = DEF_MAX_SHIFT
)
(
   input  logic                               clk,
   input  logic                               nreset,
   input  logic                               in_vld,
   output logic                               in_rdy,
   input  logic [DATA_WIDTH-1:0]              x_in,
   input  logic [DATA_WIDTH-1:0]              y_in,
   output logic                               out_vld,
   input  logic                               out_rdy,
   output logic [CORDIC_WIDTH-1:0]            x_out,
   output logic [CORDIC_WIDTH-1:0]            y_out,
   output logic [shift_width(MAX_SHIFT)-1:0]  shift_out
);

   localparam int GUARD = guard_bits(DATA_WIDTH, CORDIC_WIDTH);
   localparam int SW    = shift_width(MAX_SHIFT);

   logic                  s1_full;
   logic [DATA_WIDTH-1:0] s1_x;
   logic [DATA_WIDTH-1:0] s1_y;
   logic                  s1_adv;
   logic                  accept;
   logic [SW-1:0]         shift_c;
   logic [DATA_WIDTH-1:0] x_sh;
   logic [DATA_WIDTH-1:0] y_sh;

   // S1 drains into S2 whenever S2 is empty or being emptied this cycle.
   assign s1_adv  = s1_full && (!out_vld || out_rdy);
   assign in_rdy  = !s1_full || s1_adv;
   assign accept  = in_vld && in_rdy;

`ifdef CORDIC_IP_PRESCALE_NORM_EN
   localparam int RW = $clog2(DATA_WIDTH);

   logic [RW-1:0] rsb_x;
   logic [RW-1:0] rsb_y;

   cordic_rsb_count #(.WIDTH(DATA_WIDTH)) u_rsb_x (.din(s1_x), .rsb(rsb_x));
   cordic_rsb_count #(.WIDTH(DATA_WIDTH)) u_rsb_y (.din(s1_y), .rsb(rsb_y));

   // Common shift is the smaller headroom of the two lanes, capped at MAX_SHIFT.
   always_comb begin
      int m;
      m = MAX_SHIFT;
      if (int'(rsb_x) < m) m = int'(rsb_x);
      if (int'(rsb_y) < m) m = int'(rsb_y);
      shift_c = SW'(m);
   end
`else
   assign shift_c = '0;
`endif

   // Shifting by no more than the headroom keeps the sign bit intact.
   assign x_sh = s1_x << shift_c;
   assign y_sh = s1_y << shift_c;

   // S1: capture accepted input, empty when it moves on with nothing behind it.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_full <= 1'b0;
         s1_x    <= '0;
         s1_y    <= '0;
      end else if (accept) begin
         s1_full <= 1'b1;
         s1_x    <= x_in;
         s1_y    <= y_in;
      end else if (s1_adv) begin
         s1_full <= 1'b0;
      end
   end

   // S2: load the scaled result from S1, hold it while downstream stalls.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_vld   <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         shift_out <= '0;
      end else if (s1_adv) begin
         out_vld   <= 1'b1;
         x_out     <= {x_sh, {GUARD{1'b0}}};
         y_out     <= {y_sh, {GUARD{1'b0}}};
         shift_out <= shift_c;
      end else if (out_rdy) begin
         out_vld   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cordic_ip_prescale.sv
// tb/tb_cordic_ip_prescale.sv - directed self-checking bench for cordic_ip_prescale
module tb_cordic_ip_prescale;

   logic        clk;
   logic        nreset;
   logic        in_vld;
   logic        in_rdy;
   logic [15:0] x_in;
   logic [15:0] y_in;
   logic        out_vld;
   logic        out_rdy;
   logic [21:0] x_out;
   logic [21:0] y_out;
   logic [3:0]  shift_out;

   int total;
   int bad;

   logic [15:0] vx [10];
   logic [15:0] vy [10];
   logic [21:0] ex [10];
   logic [21:0] ey [10];
   logic [3:0]  es [10];

   int exp_q[$];
   bit mon_en;
   int occ;
   int n_out;
   bit stalled_prev;
   logic [21:0] prev_x;
   logic [21:0] prev_y;
   logic [3:0]  prev_s;

   cordic_ip_prescale #(
      .DATA_WIDTH(16),
      .CORDIC_WIDTH(22),
      .MAX_SHIFT(8)
   ) dut (
      .clk(clk),
      .nreset(nreset),
      .in_vld(in_vld),
      .in_rdy(in_rdy),
      .x_in(x_in),
      .y_in(y_in),
      .out_vld(out_vld),
      .out_rdy(out_rdy),
      .x_out(x_out),
      .y_out(y_out),
      .shift_out(shift_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic set_vec(input int i, input logic [15:0] x, input logic [15:0] y,
                          input logic [3:0] s_on, input logic [21:0] x_on, input logic [21:0] y_on,
                          input logic [21:0] x_off, input logic [21:0] y_off);
      vx[i] = x;
      vy[i] = y;
`ifdef CORDIC_IP_PRESCALE_NORM_EN
      es[i] = s_on;
      ex[i] = x_on;
      ey[i] = y_on;
`else
      es[i] = 4'd0;
      ex[i] = x_off;
      ey[i] = y_off;
`endif
   endtask

   // Present vector i until accepted; records it in the scoreboard when monitoring.
   task automatic send(input int i);
      int n;
      n = 0;
      in_vld = 1'b1;
      x_in   = vx[i];
      y_in   = vy[i];
      forever begin
         @(negedge clk);
         if (in_rdy) break;
         n++;
         if (n > 300) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      if (mon_en) exp_q.push_back(i);
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   // Single sample into an empty pipe with out_rdy high: out_vld exactly two cycles later.
   task automatic directed(input int i);
      @(posedge clk);
      #1;
      in_vld = 1'b1;
      x_in   = vx[i];
      y_in   = vy[i];
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      check($sformatf("lat1_vld[%0d]", i), out_vld, 0);
      @(posedge clk);
      #1;
      check($sformatf("lat2_vld[%0d]", i), out_vld, 1);
      check($sformatf("x[%0d]", i), x_out, ex[i]);
      check($sformatf("y[%0d]", i), y_out, ey[i]);
      check($sformatf("sh[%0d]", i), shift_out, es[i]);
      @(posedge clk);
      #1;
      check($sformatf("drain[%0d]", i), out_vld, 0);
   endtask

   // Stream monitor: ordering, stall stability and the in_rdy rule.
   always @(negedge clk) begin
      if (mon_en) begin
         if (stalled_prev) begin
            check("stall_vld", out_vld, 1);
            check("stall_x", x_out, prev_x);
            check("stall_y", y_out, prev_y);
            check("stall_sh", shift_out, prev_s);
         end
         check("in_rdy_rule", in_rdy, !(occ == 2 && !out_rdy));
         if (out_vld && out_rdy) begin
            if (exp_q.size() > 0) begin
               int k;
               k = exp_q.pop_front();
               check("st_x", x_out, ex[k]);
               check("st_y", y_out, ey[k]);
               check("st_sh", shift_out, es[k]);
            end else begin
               check("st_extra", 1, 0);
            end
            n_out++;
         end
         occ = occ + ((in_vld && in_rdy) ? 1 : 0) - ((out_vld && out_rdy) ? 1 : 0);
         stalled_prev = out_vld && !out_rdy;
         prev_x = x_out;
         prev_y = y_out;
         prev_s = shift_out;
      end
   end

   initial begin
      total = 0;
      bad = 0;
      mon_en = 1'b0;
      occ = 0;
      n_out = 0;
      stalled_prev = 1'b0;
      nreset = 1'b0;
      in_vld = 1'b0;
      x_in = '0;
      y_in = '0;
      out_rdy = 1'b1;

      //       idx x        y        s_on  x_on        y_on        x_off       y_off
      set_vec(0, 16'h0010, 16'hFFF0, 4'd8, 22'h040000, 22'h3C0000, 22'h000400, 22'h3FFC00);
      set_vec(1, 16'h8000, 16'h0001, 4'd0, 22'h200000, 22'h000040, 22'h200000, 22'h000040);
      set_vec(2, 16'h0000, 16'h0000, 4'd8, 22'h000000, 22'h000000, 22'h000000, 22'h000000);
      set_vec(3, 16'h0100, 16'h0000, 4'd6, 22'h100000, 22'h000000, 22'h004000, 22'h000000);
      set_vec(4, 16'hFF80, 16'h0400, 4'd4, 22'h3E0000, 22'h100000, 22'h3FE000, 22'h010000);
      set_vec(5, 16'h7FFF, 16'h7FFF, 4'd0, 22'h1FFFC0, 22'h1FFFC0, 22'h1FFFC0, 22'h1FFFC0);
      set_vec(6, 16'hFFFF, 16'h0001, 4'd8, 22'h3FC000, 22'h004000, 22'h3FFFC0, 22'h000040);
      set_vec(7, 16'hC000, 16'h2000, 4'd1, 22'h200000, 22'h100000, 22'h300000, 22'h080000);
      set_vec(8, 16'h0003, 16'hFFFC, 4'd8, 22'h00C000, 22'h3F0000, 22'h0000C0, 22'h3FFF00);
      set_vec(9, 16'h1234, 16'hFEDC, 4'd2, 22'h123400, 22'h3EDC00, 22'h048D00, 22'h3FB700);

      repeat (3) @(posedge clk);
      #1;
      check("rst_vld", out_vld, 0);
      check("rst_x", x_out, 0);
      check("rst_y", y_out, 0);
      check("rst_sh", shift_out, 0);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_rdy", in_rdy, 1);

      for (int i = 0; i < 10; i++) directed(i);

      // Ignored inputs: in_vld low must not create a sample.
      x_in = 16'h5555;
      y_in = 16'hAAAA;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("idle_vld", out_vld, 0);
      end

      // Stream of 10 with random backpressure.
      occ = 0;
      n_out = 0;
      stalled_prev = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      fork
         begin
            for (int i = 0; i < 10; i++) send(9 - i);
         end
         begin
            int cyc;
            cyc = 0;
            while (n_out < 10 && cyc < 600) begin
               @(posedge clk);
               #1;
               out_rdy = 1'($urandom_range(0, 1));
               cyc++;
            end
         end
      join
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      mon_en = 1'b0;
      check("stream_count", n_out, 10);
      check("stream_left", exp_q.size(), 0);

      // Reset with two samples in flight.
      repeat (2) @(posedge clk);
      #1;
      out_rdy = 1'b0;
      send(0);
      send(1);
      check("fill_vld", out_vld, 1);
      check("fill_rdy", in_rdy, 0);
      #2;
      nreset = 1'b0;
      #1;
      check("mid_rst_vld", out_vld, 0);
      check("mid_rst_x", x_out, 0);
      check("mid_rst_sh", shift_out, 0);
      check("mid_rst_rdy", in_rdy, 1);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      out_rdy = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("post_rst_vld", out_vld, 0);
      end
      directed(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
